// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving an M:1 one-bit mux; a grant lasts until its
// request drops or BURST cycles elapse, then passes through one idle cycle.
module rr_mux_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned M     = 8,
    parameter int unsigned BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] req,
    input  logic [M-1:0] A,
    output logic [M-1:0] gnt,
    output logic [N-1:0] sel,
    output logic         Y,
    output logic         valid
);

    localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [N-1:0]  ptr;
    logic [CW-1:0] cnt;
    logic          found;
    logic [N-1:0]  pick;
    logic [N-1:0]  idx;

    // First requester at or after ptr, wrapping modulo M.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < M; i++) begin
            idx = ptr + N'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            valid <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        gnt   <= M'(1) << pick;
                        sel   <= pick;
                        valid <= 1'b1;
                        ptr   <= pick + N'(1);
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    cnt <= cnt + CW'(1);
                    // A simultaneous drop and burst expiry is still one release.
                    if (!req[sel] || (cnt == CNT_LAST)) begin
                        state <= IDLE;
                        gnt   <= '0;
                        valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data path is deliberately unregistered.
    assign Y = valid & A[sel];

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter N, default 3, select width in bits.
REQ-002 Parameter M, default 8, number of requesters; SHALL equal 2**N.
REQ-003 Parameter BURST, default 4, maximum consecutive grant cycles per requester; legal range 1..16.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  M  request vector; bit i is requester i.
REQ-007 A  input  M  data vector; bit i is requester i's data bit.
REQ-008 gnt  output  M  one-hot grant, registered; all-zero when no grant is active.
REQ-009 sel  output  N  registered mux select, index of the granted requester.
REQ-010 Y  output  1  muxed data: A[sel] when valid=1, else 0.
REQ-011 valid  output  1  registered; high exactly while gnt is non-zero.

Function
REQ-012 Two-state FSM: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-013 Internal round-robin pointer ptr (N bits) names the highest-priority requester.
REQ-014 IDLE, req==0: remain IDLE; gnt=0, valid=0; sel holds its last value.
REQ-015 IDLE, req!=0 at an edge: choose k as the first set req bit searching ptr, ptr+1, ... M-1, 0, ... ptr-1 (wrapping).
REQ-016 IDLE to GRANT: at the same edge, gnt becomes onehot(k), sel becomes k, valid becomes 1, and ptr becomes (k+1) mod M (wrap-around from M-1 to 0).
REQ-017 Grant latency: one clock from the edge where a request is first sampled in IDLE to gnt/valid high.
REQ-018 Burst counter cnt SHALL clear to 0 on GRANT entry and increment on each edge spent in GRANT.
REQ-019 GRANT to IDLE happens at the first edge where req[sel]==0 or cnt==BURST-1. The maximum grant length is exactly BURST cycles.
REQ-020 If the request drops and the burst expires at the same edge, there is a single release: one transition to IDLE, ptr unchanged.
REQ-021 Every release passes through IDLE for exactly one cycle (gnt=0, valid=0) before any new grant.
REQ-022 Requests other than req[sel] SHALL NOT affect an active grant.
REQ-023 Changes on A during a grant pass combinationally to Y; there is no data registering.
REQ-024 gnt SHALL never have more than one bit set.
REQ-025 sel SHALL always equal the index of the set gnt bit whenever valid=1.

Reset
REQ-026 When rst is asserted, immediately and regardless of clk: state=IDLE, gnt=0, sel=0, valid=0, Y=0, ptr=0, cnt=0.
REQ-027 Reset asserted during GRANT SHALL abort the grant with no completion cycle.
REQ-028 After rst deasserts, arbitration restarts from ptr=0.
REQ-029 While rst is high, req SHALL be ignored.

Verification
REQ-030 Reset check: assert rst with req=8'hFF -> gnt=0, sel=0, valid=0, Y=0 immediately, before any clk edge.
REQ-031 Single request, N=3, M=8, BURST=4, A=8'b01011010:
- Stimulus: req=8'b00000100 held for 2 sampled edges, then 0.
- Response: one cycle after the request, gnt=8'b00000100, sel=2, Y=0, valid=1.
- Response: release at the edge where req is sampled low.
- Response: ptr becomes 3.
REQ-032 Round-robin rotation and burst cap, req=8'hFF held constant after reset:
- Grant order is 0,1,2,...,7,0 (wrap).
- Each grant lasts exactly 4 cycles, followed by 1 idle cycle.
- Y sequence per grant is 0,1,0,1,1,0,1,0.
REQ-033 Fairness, req=8'b10000010 held, ptr=0:
- Grants alternate 1, 7, 1, 7.
- Each grant lasts 4 cycles; Y=1 during grant 1 and Y=0 during grant 7.
REQ-034 Simultaneous events: requester drops req on the edge where cnt==BURST-1:
- Exactly one release and one idle cycle.
- No duplicate ptr advance.
REQ-035 Reset mid-operation: assert rst during the 2nd cycle of a grant to requester 5:
- Outputs clear asynchronously.
- After release with req=8'b00100001, the first grant goes to requester 0.
